// File: rtl/rtc_arb_pkg.sv
// Shared encodings for the RTC bus arbiter: FSM states and bus mux select codes.
package rtc_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_G_INIT  = 3'd1,
        ST_G_WRITE = 3'd2,
        ST_G_READ  = 3'd3,
        ST_GUARD   = 3'd4
    } arb_state_t;

    localparam logic [1:0] BUS_SEL_NONE  = 2'b00;
    localparam logic [1:0] BUS_SEL_INIT  = 2'b01;
    localparam logic [1:0] BUS_SEL_WRITE = 2'b10;
    localparam logic [1:0] BUS_SEL_READ  = 2'b11;

    // Bus mux select owned by a given state; only grant states drive the bus.
    function automatic logic [1:0] sel_of(input arb_state_t s);
        case (s)
            ST_G_INIT:  return BUS_SEL_INIT;
            ST_G_WRITE: return BUS_SEL_WRITE;
            ST_G_READ:  return BUS_SEL_READ;
            default:    return BUS_SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rtc_bus_arbiter_if.sv
// Requester-side handshake bundle of the RTC bus arbiter.
// master = requesters / sequencers, slave = arbiter.
interface rtc_bus_arbiter_if;

    logic       refresh_en;
    logic       req_init;
    logic       req_write;
    logic       req_read;
    logic       done_init;
    logic       done_write;
    logic       done_read;
    logic       gnt_init;
    logic       gnt_write;
    logic       gnt_read;
    logic [1:0] bus_sel;
    logic       busy;
    logic       timeout_err;

    modport master (
        output refresh_en, req_init, req_write, req_read,
        output done_init, done_write, done_read,
        input  gnt_init, gnt_write, gnt_read, bus_sel, busy, timeout_err
    );

    modport slave (
        input  refresh_en, req_init, req_write, req_read,
        input  done_init, done_write, done_read,
        output gnt_init, gnt_write, gnt_read, bus_sel, busy, timeout_err
    );

endinterface

// File: rtl/rtc_refresh_timer.sv
// Free-running refresh period timer: counts 0..REFRESH_CYC-1 while enabled and
// emits a one-cycle tick at the terminal count. Disabling clears the count.
module rtc_refresh_timer #(
    parameter int REFRESH_CYC = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    output logic o_tick
);

    localparam int CNT_W = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYC - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_LAST);
    assign o_tick = i_en && w_last;

    // Period counter: held at 0 while disabled, wraps to 0 after the terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (!i_en || w_last)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Arbitrates the RTC parallel bus between init, write and periodic-read
// requesters with fixed priority, a post-grant turnaround guard and a
// watchdog that revokes a grant whose owner never signals done.
module rtc_bus_arbiter
    import rtc_arb_pkg::*;
#(
    parameter int REFRESH_CYC = 100000,
    parameter int WDOG_CYC    = 1024,
    parameter int GUARD_CYC   = 4
) (
    input  logic              clk,
    input  logic              reset,
    rtc_bus_arbiter_if.slave  arb
);

    // One counter serves both the watchdog (grant states) and the guard
    // interval; it restarts from 0 on every state change.
    localparam int CNT_MAX = (WDOG_CYC > GUARD_CYC) ? WDOG_CYC : GUARD_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] WD_LAST    = CNT_W'(WDOG_CYC - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);

    arb_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_rd_pend;
    logic             r_gnt_init, r_gnt_write, r_gnt_read;
    logic [1:0]       r_bus_sel;
    logic             r_timeout;
    logic             w_tick;
    logic             w_done_cur;
    logic             w_timeout;

    rtc_refresh_timer #(
        .REFRESH_CYC (REFRESH_CYC)
    ) u_refresh (
        .clk    (clk),
        .reset  (reset),
        .i_en   (arb.refresh_en),
        .o_tick (w_tick)
    );

    // Next-state decode; only the current owner's done pulse is honoured and
    // done beats a coincident watchdog expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        w_done_cur  = 1'b0;
        case (r_state)
            ST_G_INIT:  w_done_cur = arb.done_init;
            ST_G_WRITE: w_done_cur = arb.done_write;
            ST_G_READ:  w_done_cur = arb.done_read;
            default:    w_done_cur = 1'b0;
        endcase
        case (r_state)
            ST_IDLE: begin
                if (arb.req_init)
                    w_state_nxt = ST_G_INIT;
                else if (arb.req_write)
                    w_state_nxt = ST_G_WRITE;
                else if (arb.req_read || r_rd_pend)
                    w_state_nxt = ST_G_READ;
            end
            ST_G_INIT, ST_G_WRITE, ST_G_READ: begin
                if (w_done_cur) begin
                    w_state_nxt = ST_GUARD;
                end else if (r_cnt == WD_LAST) begin
                    w_state_nxt = ST_GUARD;
                    w_timeout   = 1'b1;
                end
            end
            ST_GUARD: begin
                if (r_cnt == GUARD_LAST)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_cnt_nxt = (w_state_nxt != r_state || r_state == ST_IDLE) ? '0 : r_cnt + 1'b1;
    end

    // State register and shared watchdog/guard counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Pending periodic read: a tick wins over the clear so a refresh landing
    // on the read-entry edge still schedules one more read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_rd_pend <= 1'b0;
        else if (w_tick)
            r_rd_pend <= 1'b1;
        else if (w_state_nxt == ST_G_READ && r_state != ST_G_READ)
            r_rd_pend <= 1'b0;
    end

    // Registered grant decode from the next state, so grants and bus_sel are
    // glitch-free and always agree with each other.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gnt_init  <= 1'b0;
            r_gnt_write <= 1'b0;
            r_gnt_read  <= 1'b0;
            r_bus_sel   <= BUS_SEL_NONE;
            r_timeout   <= 1'b0;
        end else begin
            r_gnt_init  <= (w_state_nxt == ST_G_INIT);
            r_gnt_write <= (w_state_nxt == ST_G_WRITE);
            r_gnt_read  <= (w_state_nxt == ST_G_READ);
            r_bus_sel   <= sel_of(w_state_nxt);
            r_timeout   <= w_timeout;
        end
    end

    assign arb.gnt_init    = r_gnt_init;
    assign arb.gnt_write   = r_gnt_write;
    assign arb.gnt_read    = r_gnt_read;
    assign arb.bus_sel     = r_bus_sel;
    assign arb.timeout_err = r_timeout;
    assign arb.busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed self-checking bench for rtc_bus_arbiter with short timing parameters.
module tb_rtc_bus_arbiter;

    localparam int REFRESH_CYC = 50;
    localparam int WDOG_CYC    = 20;
    localparam int GUARD_CYC   = 2;

    // Output vector {gnt_init, gnt_write, gnt_read, bus_sel[1:0], busy, timeout_err}
    localparam logic [6:0] O_IDLE  = 7'b000_00_0_0;
    localparam logic [6:0] O_INIT  = 7'b100_01_1_0;
    localparam logic [6:0] O_WRITE = 7'b010_10_1_0;
    localparam logic [6:0] O_READ  = 7'b001_11_1_0;
    localparam logic [6:0] O_GUARD = 7'b000_00_1_0;
    localparam logic [6:0] O_TOUT  = 7'b000_00_1_1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rtc_bus_arbiter_if arb();

    rtc_bus_arbiter #(
        .REFRESH_CYC (REFRESH_CYC),
        .WDOG_CYC    (WDOG_CYC),
        .GUARD_CYC   (GUARD_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .arb   (arb)
    );

    always #5 clk = ~clk;

    logic [6:0] outs;
    assign outs = {arb.gnt_init, arb.gnt_write, arb.gnt_read, arb.bus_sel, arb.busy, arb.timeout_err};

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Continuous invariant: at most one grant, bus_sel consistent with it.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            logic [1:0] exp_sel;
            exp_sel = arb.gnt_init ? 2'b01 : arb.gnt_write ? 2'b10 : arb.gnt_read ? 2'b11 : 2'b00;
            checks++;
            if (!$onehot0({arb.gnt_init, arb.gnt_write, arb.gnt_read}) || arb.bus_sel !== exp_sel) begin
                errors++;
                $display("FAIL mon_onehot_sel: got gnt=%b sel=%b want onehot0 sel=%b",
                         {arb.gnt_init, arb.gnt_write, arb.gnt_read}, arb.bus_sel, exp_sel);
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        arb.refresh_en = 1'b0;
        arb.req_init = 1'b0; arb.req_write = 1'b0; arb.req_read = 1'b0;
        arb.done_init = 1'b0; arb.done_write = 1'b0; arb.done_read = 1'b0;
        step(2);
        checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL t0_reset_outs: got %b want %b", outs, O_IDLE); end
    endtask

    task automatic test_refresh();
        arb.refresh_en = 1'b1;
        reset = 1'b0;
        step(50);
        checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL t1_idle_c50: got %b want %b", outs, O_IDLE); end
        step(1);
        checks++; if (outs !== O_READ) begin errors++; $display("FAIL t1_grant_c51: got %b want %b", outs, O_READ); end
        step(9);
        arb.done_read = 1'b1; step(1); arb.done_read = 1'b0;
        checks++; if (outs !== O_GUARD) begin errors++; $display("FAIL t1_drop_after_done: got %b want %b", outs, O_GUARD); end
        step(1);
        checks++; if (outs !== O_GUARD) begin errors++; $display("FAIL t1_guard_2nd: got %b want %b", outs, O_GUARD); end
        step(1);
        checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL t1_idle_after_guard: got %b want %b", outs, O_IDLE); end
        step(37);
        checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL t1_idle_c100: got %b want %b", outs, O_IDLE); end
        step(1);
        checks++; if (outs !== O_READ) begin errors++; $display("FAIL t1_grant_c101: got %b want %b", outs, O_READ); end
        arb.done_read = 1'b1; step(1); arb.done_read = 1'b0;
        step(2);
        arb.refresh_en = 1'b0;
        checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL t1_final_idle: got %b want %b", outs, O_IDLE); end
    endtask

    task automatic test_priority();
        arb.req_init = 1'b1; arb.req_write = 1'b1; arb.req_read = 1'b1;
        step(1);
        checks++; if (outs !== O_INIT) begin errors++; $display("FAIL t2_init_first: got %b want %b", outs, O_INIT); end
        arb.req_init = 1'b0;
        step(3);
        arb.done_init = 1'b1; step(1); arb.done_init = 1'b0;
        checks++; if (outs !== O_GUARD) begin errors++; $display("FAIL t2_guard_after_init: got %b want %b", outs, O_GUARD); end
        step(2);
        checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL t2_idle_gap: got %b want %b", outs, O_IDLE); end
        step(1);
        checks++; if (outs !== O_WRITE) begin errors++; $display("FAIL t2_write_second: got %b want %b", outs, O_WRITE); end
        arb.req_write = 1'b0;
        step(2);
        arb.done_write = 1'b1; step(1); arb.done_write = 1'b0;
        checks++; if (outs !== O_GUARD) begin errors++; $display("FAIL t2_guard_after_write: got %b want %b", outs, O_GUARD); end
        step(3);
        checks++; if (outs !== O_READ) begin errors++; $display("FAIL t2_read_third: got %b want %b", outs, O_READ); end
        arb.req_read = 1'b0;
        arb.done_read = 1'b1; step(1); arb.done_read = 1'b0;
        step(2);
        checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL t2_final_idle: got %b want %b", outs, O_IDLE); end
    endtask

    task automatic test_watchdog();
        arb.req_write = 1'b1; step(1); arb.req_write = 1'b0;
        checks++; if (outs !== O_WRITE) begin errors++; $display("FAIL t3_write_grant: got %b want %b", outs, O_WRITE); end
        step(19);
        checks++; if (outs !== O_WRITE) begin errors++; $display("FAIL t3_held_cnt19: got %b want %b", outs, O_WRITE); end
        step(1);
        checks++; if (outs !== O_TOUT) begin errors++; $display("FAIL t3_timeout_pulse: got %b want %b", outs, O_TOUT); end
        step(1);
        checks++; if (outs !== O_GUARD) begin errors++; $display("FAIL t3_pulse_single: got %b want %b", outs, O_GUARD); end
        step(1);
        checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL t3_idle_after_tout: got %b want %b", outs, O_IDLE); end
        arb.req_write = 1'b1; step(1); arb.req_write = 1'b0;
        checks++; if (outs !== O_WRITE) begin errors++; $display("FAIL t3_write_regrant: got %b want %b", outs, O_WRITE); end
        step(19);
        arb.done_write = 1'b1; step(1); arb.done_write = 1'b0;
        checks++; if (outs !== O_GUARD) begin errors++; $display("FAIL t3_done_wins: got %b want %b", outs, O_GUARD); end
        step(2);
        checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL t3_final_idle: got %b want %b", outs, O_IDLE); end
    endtask

    task automatic test_read_pending();
        arb.refresh_en = 1'b1;
        step(40);
        arb.req_read = 1'b1; step(1); arb.req_read = 1'b0;
        checks++; if (outs !== O_READ) begin errors++; $display("FAIL t4_read_grant: got %b want %b", outs, O_READ); end
        step(3);
        arb.done_write = 1'b1; step(1); arb.done_write = 1'b0;
        checks++; if (outs !== O_READ) begin errors++; $display("FAIL t4_foreign_done_ignored: got %b want %b", outs, O_READ); end
        step(6);
        arb.refresh_en = 1'b0;
        checks++; if (outs !== O_READ) begin errors++; $display("FAIL t4_held_over_tick: got %b want %b", outs, O_READ); end
        step(3);
        arb.done_read = 1'b1; step(1); arb.done_read = 1'b0;
        checks++; if (outs !== O_GUARD) begin errors++; $display("FAIL t4_guard: got %b want %b", outs, O_GUARD); end
        step(2);
        checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL t4_idle_gap: got %b want %b", outs, O_IDLE); end
        step(1);
        checks++; if (outs !== O_READ) begin errors++; $display("FAIL t4_second_read: got %b want %b", outs, O_READ); end
        arb.done_read = 1'b1; step(1); arb.done_read = 1'b0;
        step(2);
        checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL t4_idle_after_2nd: got %b want %b", outs, O_IDLE); end
        step(3);
        checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL t4_no_third_read: got %b want %b", outs, O_IDLE); end
    endtask

    task automatic test_reset_mid_grant();
        arb.req_init = 1'b1;
        step(1);
        checks++; if (outs !== O_INIT) begin errors++; $display("FAIL t5_init_grant: got %b want %b", outs, O_INIT); end
        step(2);
        reset = 1'b1;
        #1;
        checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL t5_async_clear: got %b want %b", outs, O_IDLE); end
        step(1);
        checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL t5_held_in_reset: got %b want %b", outs, O_IDLE); end
        #2;
        reset = 1'b0;
        step(1);
        checks++; if (outs !== O_INIT) begin errors++; $display("FAIL t5_regrant: got %b want %b", outs, O_INIT); end
        arb.req_init = 1'b0;
        arb.done_init = 1'b1; step(1); arb.done_init = 1'b0;
        step(2);
        checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL t5_final_idle: got %b want %b", outs, O_IDLE); end
    endtask

    initial begin
        test_reset();
        test_refresh();
        test_priority();
        test_watchdog();
        test_read_pending();
        test_reset_mid_grant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net against a runaway simulation.
    initial begin
        #100000;
        $display("FAIL tb_time_limit: got no finish want finish before 100000");
        $fatal(1);
    end

endmodule
